// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble and D-stage forwarding control for a 5-stage MIPS pipeline,
// using a shadow {wa, tnew} pipeline of the in-flight E/M/W instructions.
module hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int LINK_REG = 31,
    parameter int TNEW_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_j,
    input  logic            d_r,
    input  logic            d_i,
    input  logic            d_ld,
    input  logic            d_st,
    input  logic            d_jal,
    input  logic [RA_W-1:0] d_rs,
    input  logic [RA_W-1:0] d_rt,
    input  logic [RA_W-1:0] d_rd,
    output logic            stall,
    output logic            pc_en,
    output logic            d_en,
    output logic            e_clr,
    output logic [1:0]      fwd_d_rs,
    output logic [1:0]      fwd_d_rt,
    output logic [RA_W-1:0] e_wa
);

    logic              use_rs, use_rt;
    logic [TNEW_W-1:0] tuse_rs, tuse_rt;
    logic [RA_W-1:0]   d_wa, e_wa_q, m_wa, w_wa;
    logic [TNEW_W-1:0] d_tnew, e_tnew, m_tnew, w_tnew;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - TNEW_W'(1);
    endfunction

    // A source must wait if a producer in E or M will not have its result by the time it is used.
    function automatic logic haz(input logic [RA_W-1:0] a, input logic used, input logic [TNEW_W-1:0] tuse);
        return (a != '0) && used &&
               (((a == e_wa_q) && (e_tnew > tuse)) || ((a == m_wa) && (m_tnew > tuse)));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] a);
        return (a == '0)                        ? 2'd0 :
               ((a == e_wa_q) && (e_tnew == '0)) ? 2'd1 :
               ((a == m_wa)   && (m_tnew == '0)) ? 2'd2 :
               ((a == w_wa)   && (w_tnew == '0)) ? 2'd3 : 2'd0;
    endfunction

    always_comb begin
        use_rs   = d_j | d_r | d_i | d_ld | d_st;
        tuse_rs  = d_j ? TNEW_W'(0) : TNEW_W'(1);
        use_rt   = d_j | d_r | d_st;
        tuse_rt  = d_j ? TNEW_W'(0) : d_r ? TNEW_W'(1) : TNEW_W'(2);
        d_wa     = d_r ? d_rd : (d_i | d_ld) ? d_rt : d_jal ? RA_W'(LINK_REG) : '0;
        d_tnew   = d_ld ? TNEW_W'(2) : (d_r | d_i) ? TNEW_W'(1) : TNEW_W'(0);
        stall    = reset & (haz(d_rs, use_rs, tuse_rs) | haz(d_rt, use_rt, tuse_rt));
        pc_en    = ~stall;
        d_en     = ~stall;
        e_clr    = stall;
        fwd_d_rs = reset ? fwd_sel(d_rs) : 2'd0;
        fwd_d_rt = reset ? fwd_sel(d_rt) : 2'd0;
        e_wa     = e_wa_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_wa_q <= '0;
            e_tnew <= '0;
            m_wa   <= '0;
            m_tnew <= '0;
            w_wa   <= '0;
            w_tnew <= '0;
        end else begin
            e_wa_q <= stall ? '0 : d_wa;
            e_tnew <= stall ? '0 : d_tnew;
            m_wa   <= e_wa_q;
            m_tnew <= sat_dec(e_tnew);
            w_wa   <= m_wa;
            w_tnew <= sat_dec(m_tnew);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenario tests for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       d_j, d_r, d_i, d_ld, d_st, d_jal;
    logic [4:0] d_rs, d_rt, d_rd;
    logic       stall, pc_en, d_en, e_clr;
    logic [1:0] fwd_d_rs, fwd_d_rt;
    logic [4:0] e_wa;
    int         n_cmp = 0;
    int         n_err = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_j(d_j), .d_r(d_r), .d_i(d_i), .d_ld(d_ld), .d_st(d_st), .d_jal(d_jal),
        .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
        .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .e_wa(e_wa)
    );

    always #5 clk = ~clk;

    // Inputs are driven 1 time unit after a rising edge and sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] cls, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        {d_j, d_r, d_i, d_ld, d_st, d_jal} = cls;
        d_rs = rs;
        d_rt = rt;
        d_rd = rd;
        #1;
    endtask

    localparam logic [5:0] NOP = 6'b000000, J = 6'b100000, R = 6'b010000, JR = 6'b110000,
                           I = 6'b001000, LD = 6'b000100, ST = 6'b000010, JAL = 6'b000001;

    task automatic do_reset();
        reset = 1'b0;
        drive(NOP, 0, 0, 0);
        tick();
        reset = 1'b1;
        drive(NOP, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(R, 5'd8, 5'd8, 5'd9);
        tick();
        drive(LD, 5'd3, 5'd31, 5'd7);
        n_cmp++;
        if ({stall, pc_en, d_en, e_clr} !== 4'b0110) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0110", {stall, pc_en, d_en, e_clr});
        end
        n_cmp++;
        if ({fwd_d_rs, fwd_d_rt, e_wa} !== 9'd0) begin
            n_err++; $display("FAIL reset_fwd: got rs=%0d rt=%0d e_wa=%0d want 0/0/0", fwd_d_rs, fwd_d_rt, e_wa);
        end
        reset = 1'b1;
        drive(JR, 5'd31, 5'd0, 5'd0);
        n_cmp++;
        if ({stall, fwd_d_rs, e_wa} !== 8'd0) begin
            n_err++; $display("FAIL reset_release: got stall=%b fwd=%0d e_wa=%0d want 0/0/0", stall, fwd_d_rs, e_wa);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(LD, 5'd1, 5'd8, 5'd0);
        tick();
        drive(R, 5'd8, 5'd8, 5'd9);
        n_cmp++;
        if ({stall, pc_en, d_en, e_clr} !== 4'b1001) begin
            n_err++; $display("FAIL load_use_stall: got %b want 1001", {stall, pc_en, d_en, e_clr});
        end
        n_cmp++;
        if (e_wa !== 5'd8) begin
            n_err++; $display("FAIL load_use_e_wa: got %0d want 8", e_wa);
        end
        tick();
        n_cmp++;
        if ({stall, e_clr, fwd_d_rs, fwd_d_rt, e_wa} !== 11'd0) begin
            n_err++; $display("FAIL load_use_after: got stall=%b e_clr=%b rs=%0d rt=%0d e_wa=%0d want 0", stall, e_clr, fwd_d_rs, fwd_d_rt, e_wa);
        end
        tick();
        drive(NOP, 0, 0, 0);
        n_cmp++;
        if (e_wa !== 5'd9) begin
            n_err++; $display("FAIL load_use_advance: got e_wa=%0d want 9", e_wa);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive(I, 5'd0, 5'd5, 5'd0);
        tick();
        drive(J, 5'd5, 5'd0, 5'd0);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL branch_e_stall: got %b want 1", stall);
        end
        tick();
        n_cmp++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0_10_00) begin
            n_err++; $display("FAIL branch_m_fwd: got stall=%b rs=%0d rt=%0d want 0/2/0", stall, fwd_d_rs, fwd_d_rt);
        end
        do_reset();
        drive(LD, 5'd2, 5'd10, 5'd0);
        tick();
        drive(NOP, 0, 0, 0);
        tick();
        drive(J, 5'd3, 5'd10, 5'd0);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL branch_m_load_stall: got %b want 1", stall);
        end
    endtask

    task automatic test_store();
        do_reset();
        drive(LD, 5'd2, 5'd4, 5'd0);
        tick();
        drive(ST, 5'd2, 5'd4, 5'd0);
        n_cmp++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'd0) begin
            n_err++; $display("FAIL store_no_stall: got stall=%b rs=%0d rt=%0d want 0/0/0", stall, fwd_d_rs, fwd_d_rt);
        end
        drive(ST, 5'd4, 5'd7, 5'd0);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL store_base_stall: got %b want 1", stall);
        end
    endtask

    task automatic test_jal_jr();
        do_reset();
        drive(JAL, 5'd0, 5'd0, 5'd0);
        tick();
        drive(JR, 5'd31, 5'd0, 5'd0);
        n_cmp++;
        if ({stall, fwd_d_rs, fwd_d_rt, e_wa} !== {1'b0, 2'd1, 2'd0, 5'd31}) begin
            n_err++; $display("FAIL jal_jr: got stall=%b rs=%0d rt=%0d e_wa=%0d want 0/1/0/31", stall, fwd_d_rs, fwd_d_rt, e_wa);
        end
        do_reset();
        drive(R, 5'd1, 5'd2, 5'd0);
        tick();
        drive(J, 5'd0, 5'd0, 5'd0);
        n_cmp++;
        if ({stall, fwd_d_rs, fwd_d_rt, e_wa} !== 10'd0) begin
            n_err++; $display("FAIL zero_reg: got stall=%b rs=%0d rt=%0d e_wa=%0d want 0", stall, fwd_d_rs, fwd_d_rt, e_wa);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(JAL, 5'd0, 5'd0, 5'd0);
        tick();
        drive(JAL, 5'd0, 5'd0, 5'd0);
        tick();
        drive(JR, 5'd31, 5'd0, 5'd0);
        n_cmp++;
        if ({stall, fwd_d_rs} !== 3'b0_01) begin
            n_err++; $display("FAIL prio_e_over_m: got stall=%b rs=%0d want 0/1", stall, fwd_d_rs);
        end
        do_reset();
        drive(I, 5'd0, 5'd3, 5'd0);
        tick();
        drive(I, 5'd0, 5'd3, 5'd0);
        tick();
        drive(R, 5'd3, 5'd3, 5'd9);
        n_cmp++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0_10_10) begin
            n_err++; $display("FAIL prio_m_ready: got stall=%b rs=%0d rt=%0d want 0/2/2", stall, fwd_d_rs, fwd_d_rt);
        end
        do_reset();
        drive(I, 5'd0, 5'd6, 5'd0);
        tick();
        drive(NOP, 0, 0, 0);
        tick();
        tick();
        drive(J, 5'd6, 5'd6, 5'd0);
        n_cmp++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0_11_11) begin
            n_err++; $display("FAIL w_fwd: got stall=%b rs=%0d rt=%0d want 0/3/3", stall, fwd_d_rs, fwd_d_rt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(LD, 5'd1, 5'd12, 5'd0);
        tick();
        drive(R, 5'd12, 5'd0, 5'd13);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL mid_stall_setup: got %b want 1", stall);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({stall, pc_en, d_en, e_clr, e_wa} !== {4'b0110, 5'd0}) begin
            n_err++; $display("FAIL mid_stall_reset: got ctrl=%b e_wa=%0d want 0110/0", {stall, pc_en, d_en, e_clr}, e_wa);
        end
        tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL mid_stall_cleared: got %b want 0", stall);
        end
    endtask

    initial begin
        drive(NOP, 0, 0, 0);
        test_reset();
        test_load_use();
        test_branch();
        test_store();
        test_jal_jr();
        test_priority();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
